// File: rtl/pipe_stage_reg.sv
//-----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic pipeline stage register carrying an opaque DATA_W-bit payload
// between two core stages. It uses a valid/ready handshake, stall
// back-pressure and flush (bubble insertion). A payload taken in at edge N
// is presented downstream right after edge N.
//
// Parameters
//   DATA_W  payload width in bits (>= 1)
//   SKID    1: two-entry skid buffer, in_ready is a register output
//           0: single entry, in_ready = !valid | out_ready (combinational)
//
// Ports
//   clk              stage clock, rising edge
//   rst              asynchronous reset, active low
//   in_valid/in_ready/in_data     upstream handshake and payload
//   flush            kill every held and incoming payload
//   out_valid/out_ready/out_data  downstream handshake and payload
//   perf_stall_cnt   cycles with out_valid & !out_ready, saturating
//   perf_bubble_cnt  cycles with !out_valid, saturating
//
// Optional feature macro: PIPE_STAGE_PERF_EN adds the two perf counter
// ports. Without it they are absent and the handshake is unchanged.
//-----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 64,
   parameter bit          SKID   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_bubble_cnt
`endif
);

   // Occupancy of the stage. The main entry M is valid in ONE and FULL.
   // The skid entry S is valid only in FULL. FULL is reachable only when
   // SKID=1.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic [DATA_W-1:0] s_data_q, s_data_d;

   logic in_fire;
   logic out_fire;

   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = m_data_q;

   // With the skid entry, in_ready comes only from the state register, so
   // out_ready has no combinational path to it. Without the skid entry,
   // the stage must accept in the same cycle the downstream drains it.
   assign in_ready = SKID ? (state_q != ST_FULL)
                          : ((state_q == ST_EMPTY) | out_ready);

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // NOTE: every signal written here gets a default first. Any path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_d  = state_q;
      m_data_d = m_data_q;
      s_data_d = s_data_q;

      if (flush) begin
         // A payload taken in on this cycle counts as consumed upstream and
         // is dropped. An out fire on this cycle has already happened
         // downstream.
         state_d  = ST_EMPTY;
         m_data_d = '0;
         s_data_d = '0;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  m_data_d = in_data;
                  state_d  = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  m_data_d = in_data;
               end else if (in_fire) begin
                  // Only SKID=1 gets here. With SKID=0, in_ready in ONE
                  // equals out_ready, so an in fire implies an out fire.
                  s_data_d = in_data;
                  state_d  = ST_FULL;
               end else if (out_fire) begin
                  // Invalid entries read as zero downstream.
                  m_data_d = '0;
                  state_d  = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  m_data_d = s_data_q;
                  s_data_d = '0;
                  state_d  = ST_ONE;
               end
            end
            default: begin
               state_d  = ST_EMPTY;
               m_data_d = '0;
               s_data_d = '0;
            end
         endcase
      end
   end

   // NOTE: the data registers are reset along with the state, not just the
   // valid bits. out_data must read 0 right after reset, with no X.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_EMPTY;
         m_data_q <= '0;
         s_data_q <= '0;
      end else begin
         // NOTE: non-blocking assignments, so every register samples the
         // values from before the edge.
         state_q  <= state_d;
         m_data_q <= m_data_d;
         s_data_q <= s_data_d;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_bubble_q;

   // Saturating event counters. Flush does not clear them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_q  <= '0;
         perf_bubble_q <= '0;
      end else begin
         if (out_valid && !out_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if (!out_valid && (perf_bubble_q != 32'hFFFF_FFFF)) begin
            perf_bubble_q <= perf_bubble_q + 32'd1;
         end
      end
   end

   assign perf_stall_cnt  = perf_stall_q;
   assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
//-----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg. One instance uses SKID=1 and one
// uses SKID=0. Checks come from a directed vector table, hand-written
// corner sequences, and a random run compared against a queue-based model
// of stage occupancy.
//-----------------------------------------------------------------------------
module tb_pipe_stage_reg;

   localparam int unsigned W = 16;
   localparam logic HI = 1'b1;
   localparam logic LO = 1'b0;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic         a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
   logic [W-1:0] a_in_data, a_out_data;
   logic         b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
   logic [W-1:0] b_in_data, b_out_data;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0]  a_stall_cnt, a_bubble_cnt, b_stall_cnt, b_bubble_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(W), .SKID(1'b1)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .flush(a_flush),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
`ifdef PIPE_STAGE_PERF_EN
      , .perf_stall_cnt(a_stall_cnt), .perf_bubble_cnt(a_bubble_cnt)
`endif
   );

   pipe_stage_reg #(.DATA_W(W), .SKID(1'b0)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .flush(b_flush),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef PIPE_STAGE_PERF_EN
      , .perf_stall_cnt(b_stall_cnt), .perf_bubble_cnt(b_bubble_cnt)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // One cycle of stimulus for the SKID=1 instance: inputs, the in_ready
   // expected before the edge, and the outputs expected after it.
   typedef struct {
      logic         in_valid;
      logic [W-1:0] in_data;
      logic         out_ready;
      logic         flush;
      logic         exp_ir;
      logic         exp_ov;
      logic [W-1:0] exp_od;
   } vec_t;

   function automatic vec_t mk(input logic iv, input logic [W-1:0] id, input logic orr,
                               input logic fl, input logic ir, input logic ov,
                               input logic [W-1:0] od);
      vec_t v;
      v.in_valid = iv; v.in_data = id; v.out_ready = orr; v.flush = fl;
      v.exp_ir = ir; v.exp_ov = ov; v.exp_od = od;
      return v;
   endfunction

   task automatic idle_inputs();
      a_in_valid = LO; a_in_data = '0; a_out_ready = LO; a_flush = LO;
      b_in_valid = LO; b_in_data = '0; b_out_ready = LO; b_flush = LO;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   vec_t vecs[17];
   logic [W-1:0] qa[$];
   logic [W-1:0] qb[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Stream, then back-pressure through FULL, then flush in FULL and in ONE.
      vecs[0]  = mk(HI, 16'h11, HI, LO, HI, HI, 16'h11);
      vecs[1]  = mk(HI, 16'h22, HI, LO, HI, HI, 16'h22);
      vecs[2]  = mk(HI, 16'h33, HI, LO, HI, HI, 16'h33);
      vecs[3]  = mk(LO, 16'h00, HI, LO, HI, LO, 16'h00);
      vecs[4]  = mk(HI, 16'h0A, LO, LO, HI, HI, 16'h0A);
      vecs[5]  = mk(HI, 16'h0B, LO, LO, HI, HI, 16'h0A);
      vecs[6]  = mk(HI, 16'h0C, LO, LO, LO, HI, 16'h0A);
      vecs[7]  = mk(HI, 16'h0C, HI, LO, LO, HI, 16'h0B);
      vecs[8]  = mk(HI, 16'h0C, HI, LO, HI, HI, 16'h0C);
      vecs[9]  = mk(LO, 16'h00, HI, LO, HI, LO, 16'h00);
      vecs[10] = mk(HI, 16'h01, LO, LO, HI, HI, 16'h01);
      vecs[11] = mk(HI, 16'h02, LO, LO, HI, HI, 16'h01);
      vecs[12] = mk(HI, 16'h03, LO, HI, LO, LO, 16'h00);
      vecs[13] = mk(LO, 16'h00, HI, LO, HI, LO, 16'h00);
      vecs[14] = mk(HI, 16'h44, LO, LO, HI, HI, 16'h44);
      vecs[15] = mk(HI, 16'h55, HI, HI, HI, LO, 16'h00);
      vecs[16] = mk(LO, 16'h00, HI, LO, HI, LO, 16'h00);

      // Reset state, checked while rst is still low.
      idle_inputs();
      #1;
      check("rst_a_in_ready", 64'(a_in_ready), 64'(HI));
      check("rst_a_out_valid", 64'(a_out_valid), 64'(LO));
      check("rst_a_out_data", 64'(a_out_data), 64'(0));
      check("rst_b_in_ready", 64'(b_in_ready), 64'(HI));
      check("rst_b_out_valid", 64'(b_out_valid), 64'(LO));
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Directed table on the SKID=1 instance.
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         a_in_valid = vecs[i].in_valid; a_in_data = vecs[i].in_data;
         a_out_ready = vecs[i].out_ready; a_flush = vecs[i].flush;
         #1;
         check($sformatf("vec%0d_in_ready", i), 64'(a_in_ready), 64'(vecs[i].exp_ir));
         @(posedge clk); #1;
         check($sformatf("vec%0d_out_valid", i), 64'(a_out_valid), 64'(vecs[i].exp_ov));
         check($sformatf("vec%0d_out_data", i), 64'(a_out_data), 64'(vecs[i].exp_od));
      end
      idle_inputs();

      // SKID=0 stall: M=0x5 with out_ready low blocks in_ready at once.
      @(negedge clk);
      b_in_valid = HI; b_in_data = 16'h5; b_out_ready = LO;
      #1 check("s0_ready_empty", 64'(b_in_ready), 64'(HI));
      @(posedge clk); #1;
      check("s0_hold5_valid", 64'(b_out_valid), 64'(HI));
      check("s0_hold5_data", 64'(b_out_data), 64'(16'h5));
      @(negedge clk);
      b_in_data = 16'h6;
      #1 check("s0_ready_stalled", 64'(b_in_ready), 64'(LO));
      @(posedge clk); #1;
      check("s0_stall_keeps5", 64'(b_out_data), 64'(16'h5));
      @(negedge clk);
      b_out_ready = HI;
      #1 check("s0_ready_comb", 64'(b_in_ready), 64'(HI));
      @(posedge clk); #1;
      check("s0_out6_valid", 64'(b_out_valid), 64'(HI));
      check("s0_out6_data", 64'(b_out_data), 64'(16'h6));
      @(negedge clk);
      b_in_valid = LO;
      @(posedge clk); #1;
      check("s0_drain_valid", 64'(b_out_valid), 64'(LO));
      check("s0_drain_data", 64'(b_out_data), 64'(0));

      // Asynchronous reset between edges while both instances hold data.
      @(negedge clk);
      a_in_valid = HI; a_in_data = 16'h77; a_out_ready = LO;
      b_in_valid = HI; b_in_data = 16'h78; b_out_ready = LO;
      @(posedge clk); #1;
      check("ar_pre_a_valid", 64'(a_out_valid), 64'(HI));
      check("ar_pre_b_valid", 64'(b_out_valid), 64'(HI));
      #1 rst = 1'b0;
      #1;
      check("ar_a_valid", 64'(a_out_valid), 64'(LO));
      check("ar_a_data", 64'(a_out_data), 64'(0));
      check("ar_a_ready", 64'(a_in_ready), 64'(HI));
      check("ar_b_valid", 64'(b_out_valid), 64'(LO));
      check("ar_b_data", 64'(b_out_data), 64'(0));
      do_reset();

      // Random traffic compared against queue models of the occupancy.
      qa.delete(); qb.delete();
      for (int c = 0; c < 400; c++) begin
         logic ra, rb, ova, ovb;
         @(negedge clk);
         a_in_valid = 1'($urandom_range(0, 1)); a_in_data = 16'($urandom());
         a_out_ready = 1'($urandom_range(0, 1)); a_flush = ($urandom_range(0, 15) == 0);
         b_in_valid = 1'($urandom_range(0, 1)); b_in_data = 16'($urandom());
         b_out_ready = 1'($urandom_range(0, 1)); b_flush = ($urandom_range(0, 15) == 0);
         #1;
         ova = (qa.size() != 0);
         ovb = (qb.size() != 0);
         ra = (qa.size() < 2);
         rb = (qb.size() == 0) || b_out_ready;
         check("rnd_a_in_ready", 64'(a_in_ready), 64'(ra));
         check("rnd_a_out_valid", 64'(a_out_valid), 64'(ova));
         check("rnd_a_out_data", 64'(a_out_data), 64'(ova ? qa[0] : 16'h0));
         check("rnd_b_in_ready", 64'(b_in_ready), 64'(rb));
         check("rnd_b_out_valid", 64'(b_out_valid), 64'(ovb));
         check("rnd_b_out_data", 64'(b_out_data), 64'(ovb ? qb[0] : 16'h0));
         @(posedge clk);
         if (a_flush) qa.delete();
         else begin
            if (ova && a_out_ready) void'(qa.pop_front());
            if (a_in_valid && ra) qa.push_back(a_in_data);
         end
         if (b_flush) qb.delete();
         else begin
            if (ovb && b_out_ready) void'(qb.pop_front());
            if (b_in_valid && rb) qb.push_back(b_in_data);
         end
      end

`ifdef PIPE_STAGE_PERF_EN
      // Four empty cycles (the last one fills M), then three stalled cycles.
      do_reset();
      repeat (3) @(negedge clk);
      a_in_valid = HI; a_in_data = 16'h9;
      @(negedge clk);
      a_in_valid = LO;
      repeat (3) @(negedge clk);
      check("perf_bubble", 64'(a_bubble_cnt), 64'(32'd4));
      check("perf_stall", 64'(a_stall_cnt), 64'(32'd3));
      force dut_a.perf_stall_q = 32'hFFFF_FFFE;
      #1 release dut_a.perf_stall_q;
      repeat (3) @(negedge clk);
      check("perf_stall_sat", 64'(a_stall_cnt), 64'(32'hFFFF_FFFF));
      a_flush = HI;
      @(negedge clk);
      a_flush = LO;
      #1 check("perf_flush_keeps", 64'(a_stall_cnt), 64'(32'hFFFF_FFFF));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
